core_if_pc_gen: RTL and testbench

//  IF-stage PC generator and fetch sequencer; consumes the EX-stage redirect
//  (branch_jump/bj_pc) and turns it into fetch traffic. Issues one instruction

---
 rtl/core_if_pc_gen.sv | 109 ++++++++++
 tb/tb_core_if_pc_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_if_pc_gen.sv
// core_if_pc_gen: IF-stage PC generator and single-outstanding fetch sequencer; CORE_IF_MISALIGN_CHK_EN traps misaligned redirect targets
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
module core_if_pc_gen #(
  parameter logic [`CORE_PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      branch_jump,
  input  logic [`CORE_PC_WIDTH-1:0] bj_pc,
  output logic                      ifu_req_valid,
  input  logic                      ifu_req_ready,
  output logic [`CORE_PC_WIDTH-1:0] ifu_req_addr,
  input  logic                      ifu_rsp_valid,
  input  logic [31:0]               ifu_rsp_inst,
  output logic                      if_valid,
  input  logic                      id_ready,
  output logic [`CORE_PC_WIDTH-1:0] if_pc,
  output logic [31:0]               if_inst
`ifdef CORE_IF_MISALIGN_CHK_EN
  , output logic                    if_misalign
`endif
);
  localparam int W = `CORE_PC_WIDTH;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;
  state_t state, state_nxt;
  logic [W-1:0] pc, pc_nxt, addr, if_pc_nxt;
  logic [31:0] skid, skid_nxt, if_inst_nxt;
  logic drop, drop_nxt, if_valid_nxt, acc, busy, free, bad;
  assign ifu_req_valid = state == REQ;
  assign ifu_req_addr = addr;
  assign acc = ifu_req_valid & ifu_req_ready;
  assign free = !if_valid | id_ready;
  assign busy = (((state == WAIT) | ((state == HALT) & drop)) & !ifu_rsp_valid) | acc;
`ifdef CORE_IF_MISALIGN_CHK_EN
  assign bad = bj_pc[1:0] != 2'b00;
`else
  assign bad = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    drop_nxt = drop;
    skid_nxt = skid;
    if_valid_nxt = if_valid & !id_ready;
    if_pc_nxt = if_pc;
    if_inst_nxt = if_inst;
    if (branch_jump) begin
      pc_nxt = bj_pc;
      if_valid_nxt = bad;
      if_pc_nxt = bad ? bj_pc : if_pc;
      if_inst_nxt = bad ? NOP : if_inst;
      drop_nxt = busy | (!bad & (state == REQ));
      state_nxt = bad ? HALT : ((state == REQ) & !acc) ? REQ : busy ? WAIT : REQ;
    end else begin
      case (state)
        IDLE: state_nxt = REQ;
        REQ: state_nxt = acc ? WAIT : REQ;
        WAIT: if (ifu_rsp_valid) begin
          drop_nxt = 1'b0;
          skid_nxt = ifu_rsp_inst;
          state_nxt = (drop | free) ? REQ : HOLD;
          if (!drop & free) begin
            if_valid_nxt = 1'b1;
            if_pc_nxt = pc;
            if_inst_nxt = ifu_rsp_inst;
            pc_nxt = pc + W'(4);
          end
        end
        HOLD: if (id_ready) begin
          if_valid_nxt = 1'b1;
          if_pc_nxt = pc;
          if_inst_nxt = skid;
          pc_nxt = pc + W'(4);
          state_nxt = REQ;
        end
        default: drop_nxt = drop & !ifu_rsp_valid;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      addr <= RESET_PC;
      drop <= 1'b0;
      skid <= NOP;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_inst <= NOP;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      addr <= (state == REQ) ? addr : pc_nxt;
      drop <= drop_nxt;
      skid <= skid_nxt;
      if_valid <= if_valid_nxt;
      if_pc <= if_pc_nxt;
      if_inst <= if_inst_nxt;
    end
  end
`ifdef CORE_IF_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if_misalign <= !rst & (branch_jump ? bad : (if_misalign & if_valid_nxt));
  end
`endif
endmodule

// File: tb/tb_core_if_pc_gen.sv
// tb_core_if_pc_gen: program-order scoreboard with randomized memory/ID/redirect stimulus
module tb_core_if_pc_gen;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef CORE_IF_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic branch_jump = 1'b0;
  logic [31:0] bj_pc = '0;
  logic ifu_req_ready = 1'b0;
  logic ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_rsp_inst = '0;
  logic id_ready = 1'b0;
  logic ifu_req_valid, if_valid;
  logic [31:0] ifu_req_addr, if_pc, if_inst;
`ifdef CORE_IF_MISALIGN_CHK_EN
  logic if_misalign;
`endif
  core_if_pc_gen dut (
    .clk(clk), .rst(rst), .branch_jump(branch_jump), .bj_pc(bj_pc),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst),
    .if_valid(if_valid), .id_ready(id_ready), .if_pc(if_pc), .if_inst(if_inst)
`ifdef CORE_IF_MISALIGN_CHK_EN
    , .if_misalign(if_misalign)
`endif
  );
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;
  bit mis_mode, halted, pend;
  int cnt;
  int unsigned max_dly;
  logic [31:0] pend_addr;
  logic [31:0] acc_log[$];
  logic [31:0] xfer_log[$];
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  task automatic tick(input bit rdy, input bit idr, input bit bj, input logic [31:0] tgt);
    bit acc, xfer, mis, rsp_now, req_stall, out_stall;
    logic [31:0] a, p, ins;
    mis = bj && CHK && tgt[1:0] != 2'b00;
    rsp_now = pend && cnt == 0;
    ifu_req_ready = rdy;
    id_ready = idr;
    branch_jump = bj;
    bj_pc = tgt;
    ifu_rsp_valid = rsp_now;
    ifu_rsp_inst = rsp_now ? mem(pend_addr) : $urandom;
    #1;
    acc = ifu_req_valid && rdy;
    xfer = if_valid && idr;
    a = ifu_req_addr;
    p = if_pc;
    ins = if_inst;
    req_stall = ifu_req_valid && !rdy && !mis;
    out_stall = if_valid && !idr && !bj;
    if (acc) begin
      chk("one_outstanding", 32'(pend), 32'd0);
      acc_log.push_back(a);
    end
    if (xfer) begin
      chk("xfer_after_halt", 32'(halted), 32'd0);
      chk("if_pc_order", p, exp_pc);
      chk("if_inst_data", ins, mis_mode ? NOP : mem(p));
`ifdef CORE_IF_MISALIGN_CHK_EN
      chk("if_misalign_flag", 32'(if_misalign), 32'(mis_mode));
`endif
      xfer_log.push_back(p);
      halted = mis_mode;
      exp_pc = exp_pc + 32'd4;
    end
    if (bj) begin
      exp_pc = tgt;
      mis_mode = mis;
      halted = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rsp_now) pend = 1'b0;
    else if (pend) cnt--;
    if (acc) begin
      pend = 1'b1;
      pend_addr = a;
      cnt = int'($urandom_range(max_dly, 0));
    end
    if (bj) chk("redirect_flush", 32'(if_valid), 32'(mis));
    if (req_stall) begin
      chk("req_hold_valid", 32'(ifu_req_valid), 32'd1);
      chk("req_hold_addr", ifu_req_addr, a);
    end
    if (out_stall) begin
      chk("out_hold_valid", 32'(if_valid), 32'd1);
      chk("out_hold_pc", if_pc, p);
      chk("out_hold_inst", if_inst, ins);
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    branch_jump = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(ifu_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, NOP);
`ifdef CORE_IF_MISALIGN_CHK_EN
    chk("rst_misalign", 32'(if_misalign), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    pend = 1'b0;
    exp_pc = RST_PC;
    mis_mode = 1'b0;
    halted = 1'b0;
    acc_log.delete();
    xfer_log.delete();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, k;
    bit last, b;
    logic [31:0] t;
    max_dly = 0;
    do_reset();
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("first_valid_early", 32'(if_valid), 32'd0);
    tick(1, 1, 0, 0);
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_pc", if_pc, RST_PC);
    repeat (9) tick(1, 1, 0, 0);
    chk("seq_counts", 32'(acc_log.size() >= 3 && xfer_log.size() >= 3), 32'd1);
    if (acc_log.size() >= 3 && xfer_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("seq_req_addr", acc_log[i], RST_PC + 32'(4 * i));
        chk("seq_if_pc", xfer_log[i], RST_PC + 32'(4 * i));
      end
    end
    n = acc_log.size();
    repeat (5) tick(1, 0, 0, 0);
    chk("stall_accepts_le2", 32'(acc_log.size() - n <= 2), 32'd1);
    chk("stall_no_req", 32'(ifu_req_valid), 32'd0);
    chk("stall_full", 32'(if_valid), 32'd1);
    repeat (10) tick(1, 1, 0, 0);
    max_dly = 3;
    for (int i = 0; i < 60 && !(pend && cnt != 0); i++) tick(1, 1, 0, 0);
    chk("found_wait", 32'(pend && cnt != 0), 32'd1);
    tick(1, 1, 1, 32'h8000_0100);
    n = xfer_log.size();
    for (int i = 0; i < 60 && xfer_log.size() == n; i++) tick(1, 1, 0, 0);
    chk("wait_redir_seen", 32'(xfer_log.size() > n), 32'd1);
    if (xfer_log.size() > n) chk("wait_redir_pc", xfer_log[n], 32'h8000_0100);
    for (int i = 0; i < 60 && !(pend && cnt == 0); i++) tick(1, 1, 0, 0);
    chk("found_rsp", 32'(pend && cnt == 0), 32'd1);
    tick(1, 1, 1, 32'h8000_0200);
    chk("rsp_redir_req_valid", 32'(ifu_req_valid), 32'd1);
    chk("rsp_redir_req_addr", ifu_req_addr, 32'h8000_0200);
    n = xfer_log.size();
    for (int i = 0; i < 60 && xfer_log.size() == n; i++) tick(1, 1, 0, 0);
    chk("rsp_redir_seen", 32'(xfer_log.size() > n), 32'd1);
    if (xfer_log.size() > n) chk("rsp_redir_pc", xfer_log[n], 32'h8000_0200);
    acc_log.delete();
    tick(1, 1, 1, 32'hFFFF_FFFC);
    repeat (40) tick(1, 1, 0, 0);
    k = -1;
    foreach (acc_log[i]) if (k < 0 && acc_log[i] == 32'hFFFF_FFFC) k = i;
    chk("wrap_fetched", 32'(k >= 0 && k + 1 < acc_log.size()), 32'd1);
    if (k >= 0 && k + 1 < acc_log.size()) chk("wrap_next_addr", acc_log[k+1], 32'h0);
`ifdef CORE_IF_MISALIGN_CHK_EN
    tick(1, 0, 1, 32'h8000_0102);
    n = acc_log.size();
    chk("mis_valid", 32'(if_valid), 32'd1);
    chk("mis_flag", 32'(if_misalign), 32'd1);
    chk("mis_pc", if_pc, 32'h8000_0102);
    chk("mis_inst", if_inst, NOP);
    chk("mis_no_req", 32'(ifu_req_valid), 32'd0);
    repeat (6) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    repeat (5) tick(1, 1, 0, 0);
    chk("mis_idle_valid", 32'(if_valid), 32'd0);
    chk("mis_idle_no_acc", 32'(acc_log.size() - n), 32'd0);
    tick(1, 1, 1, 32'h8000_0300);
`else
    tick(1, 1, 1, 32'h8000_0102);
`endif
    n = xfer_log.size();
    for (int i = 0; i < 60 && xfer_log.size() == n; i++) tick(1, 1, 0, 0);
    chk("post_redir_seen", 32'(xfer_log.size() > n), 32'd1);
    if (xfer_log.size() > n) chk("post_redir_pc", xfer_log[n], CHK ? 32'h8000_0300 : 32'h8000_0102);
    last = 1'b0;
    n = xfer_log.size();
    for (int i = 0; i < 2000; i++) begin
      b = !last && $urandom_range(19, 0) == 0;
      t = $urandom;
      if (CHK || $urandom_range(3, 0) != 0) t[1:0] = 2'b00;
      tick($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, b, t);
      last = b;
    end
    chk("random_progress", 32'(xfer_log.size() - n > 100), 32'd1);
    do_reset();
    repeat (12) tick(1, 1, 0, 0);
    chk("rerst_seen", 32'(xfer_log.size() > 0), 32'd1);
    if (xfer_log.size() > 0) chk("rerst_first_pc", xfer_log[0], RST_PC);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
